tlb_op_ctrl: RTL and testbench
==============================

// Module: tlb_op_ctrl
// PURPOSE
//  Sequences privileged TLB instructions (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB) from the EX/CSR stage onto the 16-entry tlb.
//  Takes one op at a time over a valid/ready handshake and drives the tlb write, read, search-port-1 and invtlb controls.
//  Returns the search/read results for CSR write-back and requests a pipeline refetch after any TLB modification.
// PARAMETERS
//  TLBNUM  16  number of TLB entries; must be a power of 2
//  IDX_W    4  index width, log2(TLBNUM)
// PORTS  (ENT = 89b packed entry {e,vppn[18:0],asid[9:0],g,ps[5:0],lo0[25:0],lo1[25:0]}, lo = {ppn[19:0],plv[1:0],mat[1:0],d,v})
//  clk            in   1      clock
//  resetn         in   1      synchronous reset, active low
//  op_valid       in   1      op request
//  op_ready       out  1      controller idle, can accept
//  op_code        in   3      0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV, 5-7 illegal
//  op_cancel      in   1      exception/flush: abort in-flight op
//  csr_index      in   IDX_W  TLBIDX.Index
//  csr_entry      in   89     ENT built from CSRs (e = ~TLBIDX.NE, vppn/asid from TLBEHI/ASID)
//  csr_tlbr       in   1      ESTAT.Ecode==TLBR (forces e=1 on WR/FILL)
//  inv_op         in   5      INVTLB op
//  inv_asid       in   10     INVTLB rj asid
//  inv_vppn       in   19     INVTLB rk va[31:13]
//  tlb_we         out  1      tlb write enable
//  tlb_w_index    out  IDX_W  write index
//  tlb_w_entry    out  89     write data
//  tlb_r_index    out  IDX_W  read index
//  tlb_r_entry    in   89     read data (combinational from tlb)
//  tlb_s_sel      out  1      1: search port 1 driven by this block
//  tlb_s_vppn     out  19     search-port-1 vppn when tlb_s_sel=1
//  tlb_s_asid     out  10     search-port-1 asid when tlb_s_sel=1
//  tlb_s_found    in   1      search-port-1 found
//  tlb_s_index    in   IDX_W  search-port-1 index
//  tlb_inv_valid  out  1      invtlb strobe
//  tlb_inv_op     out  5      invtlb opcode
//  res_valid      out  1      1-cycle result pulse
//  res_found      out  1      SRCH hit
//  res_index      out  IDX_W  SRCH hit index, 0 on miss
//  res_entry      out  89     RD data
//  flush_req      out  1      1-cycle refetch request after WR/FILL/INV
// BEHAVIOUR
//  - FSM IDLE -> EXEC -> DONE -> IDLE. Reset: state IDLE, all registered outputs 0, fill_ctr 0. op_ready = (state==IDLE).
//  - Accept on op_valid&op_ready at cycle T. Latch op_code, csr_*, inv_*, and fill_ctr. op_valid while not ready: ignored.
//  - EXEC (T+1): outputs are driven from latched values only:
//    SRCH: tlb_s_sel=1, s_vppn/s_asid from latched csr_entry. Sample tlb_s_found/index.
//    RD:   tlb_r_index=latched csr_index. Sample tlb_r_entry; if its e=0, the result is all-zero ENT.
//    WR:   tlb_we=1, w_index=csr_index, w_entry=csr_entry with e|=csr_tlbr.
//    FILL: same as WR, but w_index=latched fill_ctr.
//    INV:  tlb_inv_valid=1, inv_op, tlb_s_sel=1 with inv_vppn/inv_asid.
//    Illegal code: no tlb strobes.
//  - tlb_we, tlb_inv_valid and tlb_s_sel are high only in EXEC (exactly 1 cycle per op).
//  - DONE (T+2): res_valid=1. res_* hold until the next res_valid. flush_req=1 iff WR/FILL/INV. op_ready returns at T+3.
//  - SRCH miss: res_found=0, res_index=0. WR/FILL/INV/illegal: res_found/res_index/res_entry unchanged.
//  - fill_ctr: IDX_W-bit free-running counter, +1 every cycle, wraps TLBNUM-1 -> 0.
//  - op_cancel in EXEC: combinationally gates tlb_we/tlb_inv_valid low that cycle. In EXEC or DONE: no res_valid or flush_req; state -> IDLE next cycle. Ignored in IDLE.
//  - resetn low at any point: state IDLE the next edge, no strobe that cycle, no pending result.
// TESTING
//  - WR idx 5 with csr_entry e=1, vppn 0x12345, then RD idx 5 -> tlb_we exactly 1 cycle at T+1; res_entry equals written ENT at T+2.
//  - SRCH asid 3 vppn 0x12345 after the above (g=0, asid 3) -> res_found=1, res_index=5. Then asid 4 -> res_found=0, res_index=0.
//  - FILL accepted when fill_ctr=15 with csr_tlbr=1 and e=0 -> w_index=15, w_entry.e=1, flush_req at T+2, fill_ctr next 0.
//  - INV op 5 asid 3 vppn 0x12345 -> tlb_inv_valid=1 and tlb_s_sel=1 at T+1, flush_req at T+2; a subsequent SRCH misses.
//  - op_cancel high during EXEC of a WR -> no tlb_we, no res_valid/flush_req, op_ready=1 next cycle, entry unchanged on RD.
//  - Back-to-back op_valid held high -> accepts every 3 cycles; resetn low in EXEC -> no strobe, op_ready=1 after reset.

Source files
------------

// File: rtl/tlb_op_ctrl_if.sv
// Op request / result bundle between the EX/CSR stage and tlb_op_ctrl.
// master = pipeline side, slave = TLB op controller.
interface tlb_op_ctrl_if #(
  parameter int IDX_W = 4
);
  logic             op_valid;
  logic             op_ready;
  logic [2:0]       op_code;
  logic             op_cancel;
  logic [IDX_W-1:0] csr_index;
  logic [88:0]      csr_entry;
  logic             csr_tlbr;
  logic [4:0]       inv_op;
  logic [9:0]       inv_asid;
  logic [18:0]      inv_vppn;
  logic             res_valid;
  logic             res_found;
  logic [IDX_W-1:0] res_index;
  logic [88:0]      res_entry;
  logic             flush_req;

  modport master (
    output op_valid, op_code, op_cancel,
    output csr_index, csr_entry, csr_tlbr,
    output inv_op, inv_asid, inv_vppn,
    input  op_ready, res_valid, res_found,
    input  res_index, res_entry, flush_req
  );

  modport slave (
    input  op_valid, op_code, op_cancel,
    input  csr_index, csr_entry, csr_tlbr,
    input  inv_op, inv_asid, inv_vppn,
    output op_ready, res_valid, res_found,
    output res_index, res_entry, flush_req
  );
endinterface

// File: rtl/tlb_op_ctrl.sv
// Sequences TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB onto the tlb ports.
// One op in flight: IDLE -> EXEC (tlb strobes) -> DONE (result pulse).
module tlb_op_ctrl #(
  parameter int TLBNUM = 16,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  tlb_op_ctrl_if.slave      op,
  output logic              tlb_we,
  output logic [IDX_W-1:0]  tlb_w_index,
  output logic [88:0]       tlb_w_entry,
  output logic [IDX_W-1:0]  tlb_r_index,
  input  logic [88:0]       tlb_r_entry,
  output logic              tlb_s_sel,
  output logic [18:0]       tlb_s_vppn,
  output logic [9:0]        tlb_s_asid,
  input  logic              tlb_s_found,
  input  logic [IDX_W-1:0]  tlb_s_index,
  output logic              tlb_inv_valid,
  output logic [4:0]        tlb_inv_op
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  localparam logic [IDX_W-1:0] CTR_MAX =
    IDX_W'(TLBNUM - 1);

  logic [1:0]       state_q, state_d;
  logic [2:0]       code_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] fill_q;
  logic [IDX_W-1:0] ctr_q;
  logic [88:0]      ent_q;
  logic             tlbr_q;
  logic [4:0]       iop_q;
  logic [9:0]       iasid_q;
  logic [18:0]      ivppn_q;

  logic             s_found_q;
  logic [IDX_W-1:0] s_index_q;
  logic [88:0]      r_entry_q;

  logic             res_found_q;
  logic [IDX_W-1:0] res_index_q;
  logic [88:0]      res_entry_q;

  logic is_srch, is_rd, is_wr, is_fill, is_inv;
  logic in_exec, in_done, kill, accept, res_v;

  always_comb begin
    is_srch = 1'b0;
    is_rd   = 1'b0;
    is_wr   = 1'b0;
    is_fill = 1'b0;
    is_inv  = 1'b0;
    unique case (1'b1)
      (code_q == OP_SRCH): is_srch = 1'b1;
      (code_q == OP_RD):   is_rd   = 1'b1;
      (code_q == OP_WR):   is_wr   = 1'b1;
      (code_q == OP_FILL): is_fill = 1'b1;
      (code_q == OP_INV):  is_inv  = 1'b1;
      default: ;
    endcase
  end

  assign in_exec = (state_q == S_EXEC);
  assign in_done = (state_q == S_DONE);
  assign kill    = op.op_cancel | ~resetn;
  assign accept  = op.op_valid & op.op_ready;
  assign res_v   = in_done & ~kill;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (op.op_valid) state_d = S_EXEC;
      S_EXEC: state_d = op.op_cancel ? S_IDLE : S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      code_q      <= '0;
      idx_q       <= '0;
      fill_q      <= '0;
      ctr_q       <= '0;
      ent_q       <= '0;
      tlbr_q      <= 1'b0;
      iop_q       <= '0;
      iasid_q     <= '0;
      ivppn_q     <= '0;
      s_found_q   <= 1'b0;
      s_index_q   <= '0;
      r_entry_q   <= '0;
      res_found_q <= 1'b0;
      res_index_q <= '0;
      res_entry_q <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= (ctr_q == CTR_MAX) ? '0 : ctr_q + 1'b1;
      if (accept) begin
        code_q  <= op.op_code;
        idx_q   <= op.csr_index;
        fill_q  <= ctr_q;
        ent_q   <= op.csr_entry;
        tlbr_q  <= op.csr_tlbr;
        iop_q   <= op.inv_op;
        iasid_q <= op.inv_asid;
        ivppn_q <= op.inv_vppn;
      end
      if (in_exec) begin
        s_found_q <= tlb_s_found;
        s_index_q <= tlb_s_found ? tlb_s_index : '0;
        r_entry_q <= tlb_r_entry[88] ? tlb_r_entry : '0;
      end
      // Architectural result only moves on a delivered pulse
      if (res_v && is_srch) begin
        res_found_q <= s_found_q;
        res_index_q <= s_index_q;
      end
      if (res_v && is_rd) begin
        res_entry_q <= r_entry_q;
      end
    end
  end

  assign op.op_ready = (state_q == S_IDLE);

  assign tlb_we        = in_exec & ~kill & (is_wr | is_fill);
  assign tlb_w_index   = is_fill ? fill_q : idx_q;
  assign tlb_w_entry   = {ent_q[88] | tlbr_q, ent_q[87:0]};
  assign tlb_r_index   = idx_q;
  assign tlb_s_sel     = in_exec & resetn & (is_srch | is_inv);
  assign tlb_s_vppn    = is_inv ? ivppn_q : ent_q[87:69];
  assign tlb_s_asid    = is_inv ? iasid_q : ent_q[68:59];
  assign tlb_inv_valid = in_exec & ~kill & is_inv;
  assign tlb_inv_op    = iop_q;

  assign op.res_valid = res_v;
  assign op.res_found =
    (res_v & is_srch) ? s_found_q : res_found_q;
  assign op.res_index =
    (res_v & is_srch) ? s_index_q : res_index_q;
  assign op.res_entry =
    (res_v & is_rd) ? r_entry_q : res_entry_q;
  assign op.flush_req =
    res_v & (is_wr | is_fill | is_inv);

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl with a 16-entry tlb model
// and a result scoreboard.
module tb_tlb_op_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  tlb_op_ctrl_if #(.IDX_W(4)) bus ();

  logic        tlb_we;
  logic [3:0]  tlb_w_index;
  logic [88:0] tlb_w_entry;
  logic [3:0]  tlb_r_index;
  logic [88:0] tlb_r_entry;
  logic        tlb_s_sel;
  logic [18:0] tlb_s_vppn;
  logic [9:0]  tlb_s_asid;
  logic        tlb_s_found;
  logic [3:0]  tlb_s_index;
  logic        tlb_inv_valid;
  logic [4:0]  tlb_inv_op;

  tlb_op_ctrl #(.TLBNUM(16), .IDX_W(4)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .op            (bus),
    .tlb_we        (tlb_we),
    .tlb_w_index   (tlb_w_index),
    .tlb_w_entry   (tlb_w_entry),
    .tlb_r_index   (tlb_r_index),
    .tlb_r_entry   (tlb_r_entry),
    .tlb_s_sel     (tlb_s_sel),
    .tlb_s_vppn    (tlb_s_vppn),
    .tlb_s_asid    (tlb_s_asid),
    .tlb_s_found   (tlb_s_found),
    .tlb_s_index   (tlb_s_index),
    .tlb_inv_valid (tlb_inv_valid),
    .tlb_inv_op    (tlb_inv_op)
  );

  // tlb model
  logic [88:0] mem [16];

  function automatic logic vmatch(logic [88:0] ent,
                                  logic [18:0] vppn);
    if (ent[57:52] == 6'd21) return ent[87:78] == vppn[18:9];
    return ent[87:69] == vppn;
  endfunction

  assign tlb_r_entry = mem[tlb_r_index];

  always_comb begin
    tlb_s_found = 1'b0;
    tlb_s_index = '0;
    for (int i = 0; i < 16; i++) begin
      if (mem[i][88] &&
          (mem[i][58] || mem[i][68:59] == tlb_s_asid) &&
          vmatch(mem[i], tlb_s_vppn)) begin
        tlb_s_found = 1'b1;
        tlb_s_index = 4'(i);
      end
    end
  end

  always @(posedge clk) begin
    if (tlb_we) mem[tlb_w_index] <= tlb_w_entry;
    if (tlb_inv_valid) begin
      for (int i = 0; i < 16; i++) begin
        logic g, am, vm, clr;
        g   = mem[i][58];
        am  = (mem[i][68:59] == tlb_s_asid);
        vm  = vmatch(mem[i], tlb_s_vppn);
        clr = 1'b0;
        case (tlb_inv_op)
          5'd0, 5'd1: clr = 1'b1;
          5'd2: clr = g;
          5'd3: clr = ~g;
          5'd4: clr = ~g & am;
          5'd5: clr = ~g & am & vm;
          5'd6: clr = (g | am) & vm;
          default: clr = 1'b0;
        endcase
        if (clr) mem[i][88] <= 1'b0;
      end
    end
  end

  // free-running fill counter model
  logic [3:0] m_ctr;
  always @(posedge clk) begin
    if (!resetn) m_ctr <= '0;
    else         m_ctr <= m_ctr + 4'd1;
  end

  typedef struct packed {
    logic        we;
    logic        inv;
    logic        ssel;
    logic [3:0]  widx;
    logic [88:0] went;
    logic [18:0] svppn;
    logic [9:0]  sasid;
    logic        res;
    logic        flush;
    logic        found;
    logic [3:0]  index;
    logic [88:0] entry;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  logic        cur_found;
  logic [3:0]  cur_index;
  logic [88:0] cur_entry;

  function automatic logic [88:0] mk_ent(
    logic e, logic [18:0] vppn, logic [9:0] asid,
    logic g, logic [5:0] ps, logic [25:0] lo0,
    logic [25:0] lo1);
    return {e, vppn, asid, g, ps, lo0, lo1};
  endfunction

  function automatic exp_t base();
    exp_t e;
    e       = '0;
    e.res   = 1'b1;
    e.found = cur_found;
    e.index = cur_index;
    e.entry = cur_entry;
    return e;
  endfunction

  task automatic chk(string tag, logic [88:0] obs,
                     logic [88:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, expv);
    end
  endtask

  task automatic pop_chk(string tag);
    exp_t e;
    chk({tag, "_sb"}, 89'(q.size() > 0), 89'd1);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({tag, "_found"}, 89'(bus.res_found), 89'(e.found));
      chk({tag, "_index"}, 89'(bus.res_index), 89'(e.index));
      chk({tag, "_entry"}, bus.res_entry, e.entry);
    end
  endtask

  // Called right after a negedge; returns on a negedge.
  task automatic run_op(string tag, logic [2:0] code,
                        logic [3:0] idx, logic [88:0] ent,
                        logic tlbr, logic [4:0] iop,
                        logic [9:0] iasid, logic [18:0] ivppn,
                        logic cancel, exp_t e);
    chk({tag, "_rdy0"}, 89'(bus.op_ready), 89'd1);
    bus.op_code   = code;
    bus.csr_index = idx;
    bus.csr_entry = ent;
    bus.csr_tlbr  = tlbr;
    bus.inv_op    = iop;
    bus.inv_asid  = iasid;
    bus.inv_vppn  = ivppn;
    bus.op_valid  = 1'b1;
    if (!cancel) q.push_back(e);
    @(negedge clk);
    bus.op_valid  = 1'b0;
    bus.op_cancel = cancel;
    #1;
    chk({tag, "_we"},   89'(tlb_we),        89'(e.we));
    chk({tag, "_inv"},  89'(tlb_inv_valid), 89'(e.inv));
    chk({tag, "_ssel"}, 89'(tlb_s_sel),     89'(e.ssel));
    chk({tag, "_busy"}, 89'(bus.op_ready),  89'd0);
    if (e.we) begin
      chk({tag, "_widx"}, 89'(tlb_w_index), 89'(e.widx));
      chk({tag, "_went"}, tlb_w_entry, e.went);
    end
    if (e.ssel) begin
      chk({tag, "_svppn"}, 89'(tlb_s_vppn), 89'(e.svppn));
      chk({tag, "_sasid"}, 89'(tlb_s_asid), 89'(e.sasid));
    end
    if (e.inv) chk({tag, "_iop"}, 89'(tlb_inv_op), 89'(iop));
    if (code == 3'd1)
      chk({tag, "_ridx"}, 89'(tlb_r_index), 89'(idx));
    @(negedge clk);
    bus.op_cancel = 1'b0;
    #1;
    chk({tag, "_resv"},  89'(bus.res_valid), 89'(e.res));
    chk({tag, "_flush"}, 89'(bus.flush_req), 89'(e.flush));
    chk({tag, "_we1"},   89'(tlb_we),        89'd0);
    if (bus.res_valid) pop_chk(tag);
    if (!cancel) begin
      cur_found = e.found;
      cur_index = e.index;
      cur_entry = e.entry;
      @(negedge clk);
    end
    chk({tag, "_rdy3"}, 89'(bus.op_ready), 89'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [88:0] e5, ef, ef_w, ef2, srch;
  exp_t        e;

  initial begin
    resetn        = 1'b0;
    bus.op_valid  = 1'b0;
    bus.op_code   = '0;
    bus.op_cancel = 1'b0;
    bus.csr_index = '0;
    bus.csr_entry = '0;
    bus.csr_tlbr  = 1'b0;
    bus.inv_op    = '0;
    bus.inv_asid  = '0;
    bus.inv_vppn  = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    cur_found = 1'b0;
    cur_index = '0;
    cur_entry = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rst_ready", 89'(bus.op_ready),  89'd1);
    chk("rst_resv",  89'(bus.res_valid), 89'd0);
    chk("rst_flush", 89'(bus.flush_req), 89'd0);
    chk("rst_we",    89'(tlb_we),        89'd0);
    chk("rst_inv",   89'(tlb_inv_valid), 89'd0);
    chk("rst_ssel",  89'(tlb_s_sel),     89'd0);
    chk("rst_found", 89'(bus.res_found), 89'd0);
    chk("rst_index", 89'(bus.res_index), 89'd0);
    chk("rst_entry", bus.res_entry,      89'd0);

    e5 = mk_ent(1'b1, 19'h12345, 10'd3, 1'b0, 6'd12,
                26'h2ABCDEF, 26'h1234567);
    e = base(); e.we = 1; e.widx = 4'd5; e.went = e5;
    e.flush = 1;
    run_op("wr5", 3'd2, 4'd5, e5, 1'b0, 5'd0, 10'd0, 19'd0,
           1'b0, e);

    e = base(); e.entry = e5;
    run_op("rd5", 3'd1, 4'd5, 89'd0, 1'b0, 5'd0, 10'd0, 19'd0,
           1'b0, e);

    srch = mk_ent(1'b0, 19'h12345, 10'd3, 1'b0, 6'd0, 26'd0,
                  26'd0);
    e = base(); e.ssel = 1; e.svppn = 19'h12345; e.sasid = 10'd3;
    e.found = 1; e.index = 4'd5;
    run_op("srch_hit", 3'd0, 4'd0, srch, 1'b0, 5'd0, 10'd0,
           19'd0, 1'b0, e);

    srch = mk_ent(1'b0, 19'h12345, 10'd4, 1'b0, 6'd0, 26'd0,
                  26'd0);
    e = base(); e.ssel = 1; e.svppn = 19'h12345; e.sasid = 10'd4;
    e.found = 0; e.index = 4'd0;
    run_op("srch_asid", 3'd0, 4'd0, srch, 1'b0, 5'd0, 10'd0,
           19'd0, 1'b0, e);

    for (int i = 0; i < 20 && m_ctr != 4'd15; i++)
      @(negedge clk);
    chk("fill_wait", 89'(m_ctr), 89'd15);
    ef   = mk_ent(1'b0, 19'h0ABCD, 10'd7, 1'b1, 6'd12,
                  26'h155, 26'h2AA);
    ef_w = mk_ent(1'b1, 19'h0ABCD, 10'd7, 1'b1, 6'd12,
                  26'h155, 26'h2AA);
    e = base(); e.we = 1; e.widx = 4'd15; e.went = ef_w;
    e.flush = 1;
    run_op("fill15", 3'd3, 4'd9, ef, 1'b1, 5'd0, 10'd0, 19'd0,
           1'b0, e);

    ef2 = mk_ent(1'b1, 19'h00777, 10'd9, 1'b0, 6'd12, 26'd1,
                 26'd2);
    e = base(); e.we = 1; e.widx = m_ctr; e.went = ef2;
    e.flush = 1;
    run_op("fill_wrap", 3'd3, 4'd9, ef2, 1'b0, 5'd0, 10'd0,
           19'd0, 1'b0, e);

    e = base(); e.entry = ef_w;
    run_op("rd15", 3'd1, 4'd15, 89'd0, 1'b0, 5'd0, 10'd0,
           19'd0, 1'b0, e);

    e = base(); e.inv = 1; e.ssel = 1; e.svppn = 19'h12345;
    e.sasid = 10'd3; e.flush = 1;
    run_op("inv5", 3'd4, 4'd0, 89'd0, 1'b0, 5'd5, 10'd3,
           19'h12345, 1'b0, e);

    srch = mk_ent(1'b0, 19'h12345, 10'd3, 1'b0, 6'd0, 26'd0,
                  26'd0);
    e = base(); e.ssel = 1; e.svppn = 19'h12345; e.sasid = 10'd3;
    e.found = 0; e.index = 4'd0;
    run_op("srch_inv", 3'd0, 4'd0, srch, 1'b0, 5'd0, 10'd0,
           19'd0, 1'b0, e);

    srch = mk_ent(1'b0, 19'h0ABCD, 10'd5, 1'b0, 6'd0, 26'd0,
                  26'd0);
    e = base(); e.ssel = 1; e.svppn = 19'h0ABCD; e.sasid = 10'd5;
    e.found = 1; e.index = 4'd15;
    run_op("srch_glob", 3'd0, 4'd0, srch, 1'b0, 5'd0, 10'd0,
           19'd0, 1'b0, e);

    e = base(); e.res = 0;
    run_op("wr_cancel", 3'd2, 4'd5, e5, 1'b0, 5'd0, 10'd0,
           19'd0, 1'b1, e);

    e = base(); e.entry = 89'd0;
    run_op("rd5_inv", 3'd1, 4'd5, 89'd0, 1'b0, 5'd0, 10'd0,
           19'd0, 1'b0, e);

    e = base();
    run_op("illegal", 3'd6, 4'd5, e5, 1'b1, 5'd5, 10'd3,
           19'h12345, 1'b0, e);

    e = base(); e.entry = ef_w;
    bus.op_code   = 3'd1;
    bus.csr_index = 4'd15;
    bus.op_valid  = 1'b1;
    for (int k = 0; k < 9; k++) begin
      chk("b2b_ready", 89'(bus.op_ready), 89'(k % 3 == 0));
      chk("b2b_resv", 89'(bus.res_valid), 89'(k % 3 == 2));
      if (bus.op_ready) q.push_back(e);
      if (bus.res_valid) pop_chk("b2b");
      @(negedge clk);
    end
    bus.op_valid = 1'b0;
    cur_entry = ef_w;

    bus.op_code   = 3'd2;
    bus.csr_index = 4'd2;
    bus.csr_entry = e5;
    bus.op_valid  = 1'b1;
    @(negedge clk);
    bus.op_valid = 1'b0;
    resetn = 1'b0;
    #1;
    chk("rstx_we",   89'(tlb_we),        89'd0);
    chk("rstx_ssel", 89'(tlb_s_sel),     89'd0);
    chk("rstx_inv",  89'(tlb_inv_valid), 89'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rstx_ready", 89'(bus.op_ready),  89'd1);
    chk("rstx_resv",  89'(bus.res_valid), 89'd0);
    chk("rstx_flush", 89'(bus.flush_req), 89'd0);
    chk("rstx_entry", bus.res_entry,      89'd0);
    cur_found = 1'b0;
    cur_index = '0;
    cur_entry = '0;

    e = base(); e.entry = ef2;
    run_op("rd2_rst", 3'd1, 4'd2, 89'd0, 1'b0, 5'd0, 10'd0,
           19'd0, 1'b0, e);

    chk("sb_drained", 89'(q.size()), 89'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
